div_seq: RTL

Sequential restoring divider, the inverse companion of the team's shift-add multiplier. It takes an unsigned W_N-bit dividend and a W_D-bit divisor and produces an unsigned quotient and remainder. It resolves one quotient bit per clock, MSB first. It uses the same start/fin handshake as the multiplier, so both blocks can be driven by the same controller.

---
 rtl/div_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider, one quotient bit per clock, MSB first
// Shares the start/fin handshake of the shift-add multiplier.
module div_seq #(
  parameter int W_N = 16,
  parameter int W_D = 8
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [W_N-1:0] N,
  input  logic [W_D-1:0] D,
  input  logic           start,
  output logic [W_N-1:0] Q,
  output logic [W_D-1:0] R,
  output logic           fin,
  output logic           busy,
  output logic           dz
);

  localparam int CW = $clog2(W_N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W_D-1:0] d_q, d_d;
  // Partial remainder kept at W_D bits: after every step it is below d,
  // so the trial value's carry bit only lives in t below.
  logic [W_D-1:0] p_q, p_d;
  logic [W_N-1:0] q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fin_q, fin_d;
  logic           busy_q, busy_d;
  logic           dz_q, dz_d;

  logic [W_D:0]   t;
  logic           ge;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    dz_d    = dz_q;

    t  = {p_q, q_q[W_N-1]};
    ge = (t >= {1'b0, d_q});

    if (start) begin
      d_d   = D;
      cnt_d = '0;
      if (D != '0) begin
        q_d     = N;
        p_d     = '0;
        fin_d   = 1'b0;
        dz_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = S_RUN;
      end else begin
        // Divide by zero resolves on the load edge with a saturated quotient.
        q_d     = '1;
        p_d     = N[W_D-1:0];
        fin_d   = 1'b1;
        dz_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          p_d   = ge ? W_D'(t - {1'b0, d_q}) : t[W_D-1:0];
          q_d   = {q_q[W_N-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W_N - 1)) begin
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign Q    = q_q;
  assign R    = p_q;
  assign fin  = fin_q;
  assign busy = busy_q;
  assign dz   = dz_q;

endmodule
